multi_cycle_control_fsm: RTL and testbench

//  Multi-cycle sequencer for the 32-bit core datapath. Replaces the single-cycle decoder.

---
 rtl/multi_cycle_control_fsm.sv | 224 ++++++++++++++++++++++
 tb/tb_multi_cycle_control_fsm.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control_fsm.sv
// Multi-cycle control sequencer for the 32-bit core datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB over one shared memory port,
// waits on the memory ready handshake, traps on illegal opcodes or memory timeout and
// counts retired instructions.
//
// Ports:
//   clk_i, rst_i         clock (rising edge) and asynchronous active-high reset
//   opcode_i             instr[31:26] from IR, sampled in DECODE
//   zero_i               ALU zero flag, used by beq/bne in EXEC
//   mem_ready_i          memory completes the current access this cycle
//   mem_req_o, mem_we_o, mem_addr_sel_o      memory port control
//   ir_write_o, pc_write_o, pc_src_o         IR / PC update control
//   alu_src_a_o, alu_src_b_o, alu_op_o       ALU operand / operation select
//   reg_write_o, reg_dst_o, mem_to_reg_o     register file write-back control
//   state_o              0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 TRAP
//   instr_retired_o      one-cycle pulse on the final cycle of each instruction
//   retire_count_o       retired instruction count, wraps
//   trap_cause_o         00 none, 01 illegal opcode, 10 memory timeout
module multi_cycle_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       opcode_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             mem_addr_sel_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_src_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic             reg_write_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic [2:0]       state_o,
    output logic             instr_retired_o,
    output logic [CNT_W-1:0] retire_count_o,
    output logic [1:0]       trap_cause_o
);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // wait_q only has to reach MEM_TIMEOUT-1; with no timeout it just wraps unused.
    localparam int unsigned    WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              retire;
    logic              stall;
    logic              timeout;

    assign stall   = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready_i;
    assign timeout = (MEM_TIMEOUT != 0) && stall && (wait_q == WAIT_LAST);

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        cause_d         = cause_q;
        retire          = 1'b0;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        mem_addr_sel_o  = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        pc_src_o        = 2'b00;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'b00;
        alu_op_o        = 2'b00;
        reg_write_o     = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_write_o  = 1'b1;
                    pc_write_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    state_d     = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = 2'b10;
                end
            end
            ST_DECODE: begin
                op_d        = opcode_i;
                alu_src_b_o = 2'b11;  // branch target computed speculatively
                case (opcode_i)
                    OP_J: begin
                        pc_write_o = 1'b1;
                        pc_src_o   = 2'b10;
                        retire     = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI: state_d = ST_EXEC;
                    default: begin
                        state_d = ST_TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            ST_EXEC: begin
                alu_src_a_o = 1'b1;
                case (op_q)
                    OP_R: begin
                        alu_op_o = 2'b10;
                        state_d  = ST_WB;
                    end
                    OP_ADDI: begin
                        alu_src_b_o = 2'b10;
                        state_d     = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b_o = 2'b10;
                        state_d     = ST_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        alu_op_o   = 2'b01;
                        pc_src_o   = 2'b01;
                        pc_write_o = (op_q == OP_BEQ) ? zero_i : !zero_i;
                        retire     = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                mem_req_o      = 1'b1;
                mem_addr_sel_o = 1'b1;
                mem_we_o       = (op_q == OP_SW);
                if (mem_ready_i) begin
                    if (op_q == OP_SW) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout) begin
                    state_d = ST_TRAP;
                    cause_d = 2'b10;
                end
            end
            ST_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = (op_q == OP_R);
                mem_to_reg_o = (op_q == OP_LW);
                retire       = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_TRAP: ;
            default: state_d = ST_FETCH;
        endcase
        instr_retired_o = retire;
        // Outputs are decoded combinationally, so mask them while reset is held.
        if (rst_i) begin
            mem_req_o       = 1'b0;
            mem_we_o        = 1'b0;
            mem_addr_sel_o  = 1'b0;
            ir_write_o      = 1'b0;
            pc_write_o      = 1'b0;
            pc_src_o        = 2'b00;
            alu_src_a_o     = 1'b0;
            alu_src_b_o     = 2'b00;
            alu_op_o        = 2'b00;
            reg_write_o     = 1'b0;
            reg_dst_o       = 1'b0;
            mem_to_reg_o    = 1'b0;
            instr_retired_o = 1'b0;
        end
    end

    // Wait counter restarts on any completed access or state change.
    always_comb begin
        wait_d = '0;
        if (stall && (state_d == state_q)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
            wait_q  <= '0;
            cause_q <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign state_o        = state_q;
    assign retire_count_o = cnt_q;
    assign trap_cause_o   = cause_q;

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Randomized scoreboard bench for multi_cycle_control_fsm. The driver walks each
// instruction through its phases, pushing the expected per-cycle control word into a
// queue; the monitor pops one word per cycle on the falling edge and compares.
module tb_multi_cycle_control_fsm;

    localparam int unsigned TIMEOUT = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [2:0] state;
        logic       instr_retired;
        logic [1:0] trap_cause;
        logic [3:0] retire_count;
    } ctl_t;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [5:0] opcode_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       mem_req_o, mem_we_o, mem_addr_sel_o, ir_write_o, pc_write_o;
    logic [1:0] pc_src_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o, alu_op_o;
    logic       reg_write_o, reg_dst_o, mem_to_reg_o;
    logic [2:0] state_o;
    logic       instr_retired_o;
    logic [3:0] retire_count_o;
    logic [1:0] trap_cause_o;

    ctl_t       act;
    ctl_t       mon_e;
    ctl_t       exp_q[$];
    logic [3:0] exp_cnt = '0;
    logic [1:0] exp_cause = '0;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    multi_cycle_control_fsm #(
        .MEM_TIMEOUT(TIMEOUT),
        .CNT_W      (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .opcode_i       (opcode_i),
        .zero_i         (zero_i),
        .mem_ready_i    (mem_ready_i),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_sel_o (mem_addr_sel_o),
        .ir_write_o     (ir_write_o),
        .pc_write_o     (pc_write_o),
        .pc_src_o       (pc_src_o),
        .alu_src_a_o    (alu_src_a_o),
        .alu_src_b_o    (alu_src_b_o),
        .alu_op_o       (alu_op_o),
        .reg_write_o    (reg_write_o),
        .reg_dst_o      (reg_dst_o),
        .mem_to_reg_o   (mem_to_reg_o),
        .state_o        (state_o),
        .instr_retired_o(instr_retired_o),
        .retire_count_o (retire_count_o),
        .trap_cause_o   (trap_cause_o)
    );

    always #5 clk_i = ~clk_i;

    assign act = {mem_req_o, mem_we_o, mem_addr_sel_o, ir_write_o, pc_write_o, pc_src_o,
                  alu_src_a_o, alu_src_b_o, alu_op_o, reg_write_o, reg_dst_o, mem_to_reg_o,
                  state_o, instr_retired_o, trap_cause_o, retire_count_o};

    // Monitor: one expected control word per driven cycle.
    always @(negedge clk_i) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (act !== mon_e) begin
                errors++;
                $display("FAIL ctl cycle %0d: got %h (state %0d) want %h (state %0d)",
                         cyc, act, act.state, mon_e, mon_e.state);
            end
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] r6();
        return 6'($urandom);
    endfunction

    function automatic logic r1();
        return 1'($urandom);
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
               op == OP_BNE || op == OP_J || op == OP_ADDI;
    endfunction

    function automatic ctl_t base(input logic [2:0] st);
        ctl_t e = '0;
        e.state        = st;
        e.trap_cause   = exp_cause;
        e.retire_count = exp_cnt;
        return e;
    endfunction

    task automatic step(input logic [5:0] op, input logic z, input logic rdy, input logic r,
                        input ctl_t e);
        rst_i       = r;
        opcode_i    = op;
        zero_i      = z;
        mem_ready_i = rdy;
        exp_q.push_back(e);
        if (e.instr_retired) exp_cnt = exp_cnt + 4'd1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input int n);
        ctl_t z = '0;
        exp_cnt   = '0;
        exp_cause = '0;
        for (int i = 0; i < n; i++) step(r6(), r1(), 1'b1, 1'b1, z);
    endtask

    task automatic trap_hold(input int n);
        for (int i = 0; i < n; i++) step(r6(), r1(), r1(), 1'b0, base(3'd5));
    endtask

    // Instruction-level model: fs/ms are stall cycles in FETCH/MEM (TIMEOUT stalls trap).
    task automatic do_instr(input logic [5:0] op, input logic z, input int fs, input int ms,
                            input bit abort, output bit trapped, output bit aborted);
        ctl_t e;
        trapped = 1'b0;
        aborted = 1'b0;
        for (int i = 0; i < fs; i++) begin
            e = base(3'd0);
            e.mem_req = 1'b1;
            step(r6(), r1(), 1'b0, 1'b0, e);
        end
        if (fs >= int'(TIMEOUT)) begin
            exp_cause = 2'b10;
            trapped   = 1'b1;
            return;
        end
        e = base(3'd0);
        e.mem_req   = 1'b1;
        e.ir_write  = 1'b1;
        e.pc_write  = 1'b1;
        e.alu_src_b = 2'b01;
        step(r6(), r1(), 1'b1, 1'b0, e);
        e = base(3'd1);
        e.alu_src_b = 2'b11;
        if (!is_legal(op)) begin
            step(op, r1(), r1(), 1'b0, e);
            exp_cause = 2'b01;
            trapped   = 1'b1;
            return;
        end
        if (op == OP_J) begin
            e.pc_write      = 1'b1;
            e.pc_src        = 2'b10;
            e.instr_retired = 1'b1;
            step(op, r1(), r1(), 1'b0, e);
            return;
        end
        step(op, r1(), r1(), 1'b0, e);
        e = base(3'd2);
        e.alu_src_a = 1'b1;
        if (op == OP_BEQ || op == OP_BNE) begin
            e.alu_op        = 2'b01;
            e.pc_src        = 2'b01;
            e.pc_write      = (op == OP_BEQ) ? z : !z;
            e.instr_retired = 1'b1;
            step(r6(), z, r1(), 1'b0, e);
            return;
        end
        e.alu_src_b = (op == OP_R) ? 2'b00 : 2'b10;
        e.alu_op    = (op == OP_R) ? 2'b10 : 2'b00;
        step(r6(), r1(), r1(), 1'b0, e);
        if (op == OP_LW || op == OP_SW) begin
            e = base(3'd3);
            e.mem_req      = 1'b1;
            e.mem_addr_sel = 1'b1;
            e.mem_we       = (op == OP_SW);
            for (int i = 0; i < ms; i++) step(r6(), r1(), 1'b0, 1'b0, e);
            if (ms >= int'(TIMEOUT)) begin
                exp_cause = 2'b10;
                trapped   = 1'b1;
                return;
            end
            if (abort) begin
                aborted = 1'b1;
                return;
            end
            e.instr_retired = (op == OP_SW);
            step(r6(), r1(), 1'b1, 1'b0, e);
            if (op == OP_SW) return;
        end
        e = base(3'd4);
        e.reg_write     = 1'b1;
        e.instr_retired = 1'b1;
        e.reg_dst       = (op == OP_R);
        e.mem_to_reg    = (op == OP_LW);
        step(r6(), r1(), r1(), 1'b0, e);
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        bit         tr, ab;
        int         fs, ms;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};
        rst_i       = 1'b1;
        opcode_i    = '0;
        zero_i      = 1'b0;
        mem_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        do_reset(2);

        // R then addi, no stalls
        do_instr(OP_R, 1'b0, 0, 0, 1'b0, tr, ab);
        do_instr(OP_ADDI, 1'b0, 0, 0, 1'b0, tr, ab);
        // lw with three MEM stalls, then sw
        do_instr(OP_LW, 1'b0, 0, 3, 1'b0, tr, ab);
        do_instr(OP_SW, 1'b0, 0, 0, 1'b0, tr, ab);
        // branches, both zero values
        do_instr(OP_BEQ, 1'b1, 0, 0, 1'b0, tr, ab);
        do_instr(OP_BEQ, 1'b0, 0, 0, 1'b0, tr, ab);
        do_instr(OP_BNE, 1'b1, 0, 0, 1'b0, tr, ab);
        do_instr(OP_BNE, 1'b0, 0, 0, 1'b0, tr, ab);
        // illegal opcode traps, holds, then reset recovers
        do_instr(6'b111111, 1'b0, 0, 0, 1'b0, tr, ab);
        trap_hold(20);
        do_reset(2);
        // fetch timeout, then ready arriving on the last allowed cycle
        do_instr(OP_R, 1'b0, 4, 0, 1'b0, tr, ab);
        trap_hold(3);
        do_reset(2);
        do_instr(OP_R, 1'b0, 3, 0, 1'b0, tr, ab);
        // MEM timeout
        do_instr(OP_LW, 1'b0, 1, 4, 1'b0, tr, ab);
        trap_hold(3);
        do_reset(2);
        // 17 jumps wrap the 4-bit counter to 1
        for (int i = 0; i < 17; i++) do_instr(OP_J, 1'b0, 0, 0, 1'b0, tr, ab);
        // reset in the middle of a stalled lw
        do_instr(OP_LW, 1'b0, 0, 2, 1'b1, tr, ab);
        do_reset(3);

        for (int k = 0; k < 200; k++) begin
            op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 99) < 4) begin
                do op = r6(); while (is_legal(op));
            end
            fs = ($urandom_range(0, 19) == 0) ? 4 : $urandom_range(0, 3);
            ms = ($urandom_range(0, 19) == 0) ? 4 : $urandom_range(0, 3);
            do_instr(op, r1(), fs, ms, ($urandom_range(0, 24) == 0), tr, ab);
            if (tr) trap_hold($urandom_range(1, 4));
            if (tr || ab) do_reset($urandom_range(1, 3));
        end

        @(negedge clk_i);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected words left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
